// File: rtl/register_file_reader_if.sv
// Valid/ready word stream carrying the swept register file contents.
// The master drives data/valid/last; the slave answers with ready.
interface register_file_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/register_file_reader.sv
// Sweeps a contiguous register file range out over a valid/ready stream.
// Define CLEAR_ON_READ_EN to zero each word right after it is read.
module register_file_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_q,
  register_file_reader_if.master m
);

  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef CLEAR_ON_READ_EN
  typedef enum logic [2:0] {
    IDLE,
    READ,
    CLEAR,
    DRAIN,
    FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_t;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   clamped;
  logic                  inflight;
  logic                  inflight_last;

  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] tail;
  logic                  tail_last;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [1:0]            pending;

  assign pop  = m.valid && m.ready;
  assign push = inflight;

  // words that will occupy the buffer after this edge, before any new issue
  always_comb begin
    pending = count + {1'b0, inflight} - {1'b0, pop};
  end

  // a new read may only go out if its word is guaranteed a buffer slot
  always_comb begin
    issue = (state == READ) && (pending < 2'd2);
  end

  // requests longer than the RAM wrap onto themselves, so clamp them
  always_comb begin
    clamped = (length > DEPTH) ? DEPTH : length;
  end

  assign ram_addr  = addr;
  assign ram_wdata = '0;
`ifdef CLEAR_ON_READ_EN
  assign ram_we    = (state == CLEAR);
`else
  assign ram_we    = 1'b0;
`endif

  assign m.data  = head;
  assign m.valid = (count != 2'd0);
  assign m.last  = m.valid && head_last;

  // sweep sequencer: address, remaining count, in-flight tag, status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == ONE);
      done          <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= clamped;
            busy      <= 1'b1;
            // empty sweeps skip READ and finish via DRAIN
            state     <= (clamped == '0) ? DRAIN : READ;
          end
        end
        READ: begin
          if (issue) begin
            remaining <= remaining - ONE;
`ifdef CLEAR_ON_READ_EN
            state     <= CLEAR;
`else
            addr      <= addr + 1'b1;
            if (remaining == ONE) begin
              state <= DRAIN;
            end
`endif
          end
        end
`ifdef CLEAR_ON_READ_EN
        CLEAR: begin
          addr  <= addr + 1'b1;
          state <= (remaining == '0) ? DRAIN : READ;
        end
`endif
        DRAIN: begin
          if (pending == 2'd0) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // two-entry output buffer; head is presented on the stream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= 2'd0;
      head      <= '0;
      head_last <= 1'b0;
      tail      <= '0;
      tail_last <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head      <= ram_q;
            head_last <= inflight_last;
          end else begin
            tail      <= ram_q;
            tail_last <= inflight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head      <= tail;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head      <= ram_q;
            head_last <= inflight_last;
          end else begin
            head      <= tail;
            head_last <= tail_last;
            tail      <= ram_q;
            tail_last <= inflight_last;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_reader.sv
// Scoreboard bench for register_file_reader with a behavioural RAM.
// Build with CLEAR_ON_READ_EN to also exercise clear-on-read.
module tb_register_file_reader;

`ifdef CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;

  register_file_reader_if #(.DATA_WIDTH(32)) m ();

  register_file_reader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_q     (ram_q),
    .m         (m)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i) + 32'h100;
      loaded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_q <= mem[ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int base = 0;
  int mode = 0;
  int stall_until = 0;
  int beats = 0;
  bit [15:0] lfsr = 16'hACE1;
  logic [32:0] exp_q [$];

  always @(posedge clk) edge_n <= edge_n + 1;

  // ready pattern: 0 = always, 1 = pseudo-random, 2 = held low then high
  always @(posedge clk) begin
    #1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    case (mode)
      1:       m.ready = lfsr[0];
      2:       m.ready = (edge_n - base + 1) > stall_until;
      default: m.ready = 1'b1;
    endcase
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        held_valid = 1'b0;
  logic [31:0] held_data;

  // monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (m.valid) begin
      if (held_valid) begin
        checks++;
        if (m.data !== held_data) begin
          failures++;
          $display("FAIL stall_stable: got %0h expected %0h",
                   m.data, held_data);
        end
      end
      if (m.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat: got %0h expected none", m.data);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({m.last, m.data} !== e) begin
            failures++;
            $display("FAIL beat: got last=%0b data=%0h expected last=%0b data=%0h",
                     m.last, m.data, e[32], e[31:0]);
          end
        end
        beats++;
        held_valid = 1'b0;
      end else begin
        held_valid = 1'b1;
        held_data  = m.data;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic expect_words(input logic [31:0] first, input int n,
                              input bit zero);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = zero ? 32'h0 : first + 32'(i);
      exp_q.push_back({(i == n - 1), w});
    end
  endtask

  task automatic start_sweep(input logic [7:0] a, input logic [8:0] l);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    length     = l;
    base       = edge_n + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int k0, input int budget,
                           output int dc, output int nd,
                           output int fv, output int b1,
                           output int bd, output int wem);
    dc = -1; nd = 0; fv = -1; b1 = -1; bd = -1; wem = 0;
    for (int k = k0; k < k0 + budget; k++) begin
      @(negedge clk);
      if (k == 1) b1 = int'(busy);
      if (m.valid && fv < 0) fv = k;
      if (ram_we && k < 32) wem = wem | (1 << k);
      if (done) begin
        nd++;
        if (dc < 0) begin
          dc = k;
          bd = int'(busy);
        end
      end
      if (dc > 0 && k >= dc + 3) break;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_m_data"}, m.data, 0);
    chk({tag, "_m_valid"}, m.valid, 0);
    chk({tag, "_m_last"}, m.last, 0);
  endtask

  function automatic int ed(input int n);
    return CLR ? 2 * n + 2 : n + 3;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nd, fv, b1, bd, wem, b0;
    reset = 1'b0;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    m.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) reset = 1'b1;

    // basic three-word sweep
    expect_words(32'h104, 3, 1'b0);
    start_sweep(8'd4, 9'd3);
    wait_done(1, 60, dc, nd, fv, b1, bd, wem);
    chk("t1_first_valid", fv, 3);
    chk("t1_busy_c1", b1, 1);
    chk("t1_done_cycle", dc, ed(3));
    chk("t1_done_count", nd, 1);
    chk("t1_busy_at_done", bd, 0);
    chk("t1_drained", exp_q.size(), 0);
`ifndef CLEAR_ON_READ_EN
    chk("t1_no_write", wem, 0);
`endif

    // address wrap past the top of the RAM
    exp_q.push_back({1'b0, 32'h1FE});
    exp_q.push_back({1'b0, 32'h1FF});
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b1, 32'h101});
    start_sweep(8'd254, 9'd4);
    wait_done(1, 60, dc, nd, fv, b1, bd, wem);
    chk("wrap_done_cycle", dc, ed(4));
    chk("wrap_done_count", nd, 1);
    chk("wrap_drained", exp_q.size(), 0);

    // zero-length sweep
    b0 = beats;
    start_sweep(8'd7, 9'd0);
    wait_done(1, 20, dc, nd, fv, b1, bd, wem);
    chk("len0_busy_c1", b1, 1);
    chk("len0_done_cycle", dc, 2);
    chk("len0_done_count", nd, 1);
    chk("len0_no_valid", fv, -1);
    chk("len0_no_beats", beats - b0, 0);

    // random backpressure
    mode = 1;
    expect_words(32'h120, 16, 1'b0);
    start_sweep(8'h20, 9'd16);
    wait_done(1, 300, dc, nd, fv, b1, bd, wem);
    chk("rnd_finished", dc > 0, 1);
    chk("rnd_done_count", nd, 1);
    chk("rnd_drained", exp_q.size(), 0);

    // long stall: only two reads may be outstanding
    mode = 2;
    stall_until = 20;
    expect_words(32'h140, 8, 1'b0);
    start_sweep(8'h40, 9'd8);
    repeat (20) @(negedge clk);
    chk("stall_issued", ram_addr, 8'h42);
    chk("stall_valid", m.valid, 1);
    chk("stall_head", m.data, 32'h140);
    wait_done(21, 100, dc, nd, fv, b1, bd, wem);
`ifndef CLEAR_ON_READ_EN
    chk("stall_done_cycle", dc, 29);
`endif
    chk("stall_done_count", nd, 1);
    chk("stall_drained", exp_q.size(), 0);
    mode = 0;

    // asynchronous reset in the middle of a sweep
    b0 = beats;
    expect_words(32'h110, 10, 1'b0);
    start_sweep(8'h10, 9'd10);
    for (int k = 0; k < 100 && beats < b0 + 5; k++) @(negedge clk);
    chk("mid_beats_seen", beats - b0 >= 5, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    #1 check_idle("midreset");
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    expect_words(32'h100, 2, CLR);
    start_sweep(8'd0, 9'd2);
    wait_done(1, 60, dc, nd, fv, b1, bd, wem);
    chk("restart_first_valid", fv, 3);
    chk("restart_done_cycle", dc, ed(2));
    chk("restart_done_count", nd, 1);
    chk("restart_drained", exp_q.size(), 0);

`ifdef CLEAR_ON_READ_EN
    // clear-on-read: old values, alternate write pulses, then zeros
    expect_words(32'h108, 4, 1'b0);
    start_sweep(8'd8, 9'd4);
    wait_done(1, 60, dc, nd, fv, b1, bd, wem);
    chk("clr_we_cycles", wem, 32'h154);
    chk("clr_done_cycle", dc, 10);
    chk("clr_drained", exp_q.size(), 0);
    expect_words(32'h0, 4, 1'b1);
    start_sweep(8'd8, 9'd4);
    wait_done(1, 60, dc, nd, fv, b1, bd, wem);
    chk("clr2_done_count", nd, 1);
    chk("clr2_drained", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
